// File: rtl/mem_resp_stage_pkg.sv
// Shared definitions for the memory response stage: load-type codes,
// FSM encodings and the stage bus widths.
package mem_resp_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LD_TYPE_W  = 3;
  localparam int ADDR_LOW_W = 2;
  localparam int PERF_W     = 32;

  localparam logic [LD_TYPE_W-1:0] LD_B  = 3'd0;
  localparam logic [LD_TYPE_W-1:0] LD_H  = 3'd1;
  localparam logic [LD_TYPE_W-1:0] LD_W  = 3'd2;
  localparam logic [LD_TYPE_W-1:0] LD_BU = 3'd4;
  localparam logic [LD_TYPE_W-1:0] LD_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } resp_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte or halfword out of the
// returned word and sign- or zero-extends it. Unknown load types return
// the full word.
import mem_resp_stage_pkg::*;

module mem_load_align #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]     data,
  input  logic [LD_TYPE_W-1:0]  ld_type,
  input  logic [ADDR_LOW_W-1:0] addr_low,
  output logic [DATA_W-1:0]     result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed byte/half, then extend according to the load type
  always_comb begin
    case (addr_low)
      2'd0:    byte_val = data[7:0];
      2'd1:    byte_val = data[15:8];
      2'd2:    byte_val = data[23:16];
      default: byte_val = data[31:24];
    endcase
    half_val = addr_low[1] ? data[31:16] : data[15:0];
    case (ld_type)
      LD_B:    result = {{(DATA_W-8){byte_val[7]}}, byte_val};
      LD_H:    result = {{(DATA_W-16){half_val[15]}}, half_val};
      LD_BU:   result = {{(DATA_W-8){1'b0}}, byte_val};
      LD_HU:   result = {{(DATA_W-16){1'b0}}, half_val};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// Second memory pipeline stage: waits for the dcache response, aligns
// load data, buffers it when writeback stalls, and discards the one
// orphaned response left behind by an exception flush.
// Optional stall counter enabled by defining MEM_RESP_PERF_CNT_EN.
import mem_resp_stage_pkg::*;

module mem_resp_stage #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pre_valid_i,
  output logic                  now_allowin_o,
  input  logic                  pre_mem_req_i,
  input  logic                  pre_mem_we_i,
  input  logic [LD_TYPE_W-1:0]  pre_ld_type_i,
  input  logic [ADDR_LOW_W-1:0] pre_addr_low_i,
  input  logic                  pre_excep_en_i,
  input  logic                  pre_regs_we_i,
  input  logic [REG_ADDR_W-1:0] pre_regs_waddr_i,
  input  logic [DATA_W-1:0]     pre_regs_wdata_i,
  input  logic [DATA_W-1:0]     pre_pc_i,
  input  logic                  excep_flush_i,
  input  logic                  data_ok_i,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic                  next_allowin_i,
  output logic                  now_to_next_valid_o,
  output logic                  regs_we_o,
  output logic [REG_ADDR_W-1:0] regs_waddr_o,
  output logic [DATA_W-1:0]     regs_wdata_o,
  output logic [DATA_W-1:0]     pc_o,
  output logic                  excep_en_o,
  output logic                  fwd_we_o,
  output logic                  fwd_stall_o,
  output logic [PERF_W-1:0]     perf_stall_cnt_o
);

  resp_state_t state_q, state_d, follow_state;

  logic                  valid_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic                  excep_en_q;
  logic                  regs_we_q;
  logic [LD_TYPE_W-1:0]  ld_type_q;
  logic [ADDR_LOW_W-1:0] addr_low_q;
  logic [REG_ADDR_W-1:0] regs_waddr_q;
  logic [DATA_W-1:0]     regs_wdata_q;
  logic [DATA_W-1:0]     pc_q;
  logic [DATA_W-1:0]     hold_q;

  logic              need_data;
  logic              ready_go;
  logic              allowin;
  logic              accept;
  logic              is_load;
  logic              regs_we;
  logic [DATA_W-1:0] load_src;
  logic [DATA_W-1:0] load_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a freshly accepted request enters WAIT; a flush with no
  // response yet leaves one response in flight, which DRAIN swallows
  always_comb begin
    follow_state = (accept && pre_mem_req_i && !pre_excep_en_i) ? ST_WAIT : ST_IDLE;
    state_d      = state_q;
    case (state_q)
      ST_IDLE: state_d = follow_state;
      ST_WAIT: begin
        if (excep_flush_i)  state_d = data_ok_i ? ST_IDLE : ST_DRAIN;
        else if (data_ok_i) state_d = next_allowin_i ? follow_state : ST_HOLD;
      end
      ST_HOLD: begin
        if (excep_flush_i)       state_d = ST_IDLE;
        else if (next_allowin_i) state_d = follow_state;
      end
      ST_DRAIN: if (data_ok_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and writeback outputs derived from state and latched fields
  always_comb begin
    need_data           = valid_q & mem_req_q & ~excep_en_q;
    ready_go            = ~need_data | ((state_q == ST_WAIT) & data_ok_i) | (state_q == ST_HOLD);
    allowin             = (~valid_q | (ready_go & next_allowin_i)) & (state_q != ST_DRAIN);
    accept              = pre_valid_i & allowin & ~excep_flush_i;
    is_load             = mem_req_q & ~mem_we_q;
    load_src            = (state_q == ST_HOLD) ? hold_q : rdata_i;
    regs_we             = valid_q & regs_we_q & ~excep_en_q & ~excep_flush_i;
    now_allowin_o       = allowin;
    now_to_next_valid_o = valid_q & ready_go & ~excep_flush_i;
    regs_we_o           = regs_we;
    fwd_we_o            = regs_we;
    fwd_stall_o         = valid_q & is_load & ~ready_go;
    excep_en_o          = valid_q & excep_en_q;
    regs_waddr_o        = regs_waddr_q;
    pc_o                = pc_q;
    regs_wdata_o        = is_load ? load_data : regs_wdata_q;
  end

  // Stage valid and instruction fields; a flush kills whatever is here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      excep_en_q   <= 1'b0;
      regs_we_q    <= 1'b0;
      ld_type_q    <= '0;
      addr_low_q   <= '0;
      regs_waddr_q <= '0;
      regs_wdata_q <= '0;
      pc_q         <= '0;
    end else begin
      if (excep_flush_i) valid_q <= 1'b0;
      else if (allowin)  valid_q <= pre_valid_i;
      if (accept) begin
        mem_req_q    <= pre_mem_req_i;
        mem_we_q     <= pre_mem_we_i;
        excep_en_q   <= pre_excep_en_i;
        regs_we_q    <= pre_regs_we_i;
        ld_type_q    <= pre_ld_type_i;
        addr_low_q   <= pre_addr_low_i;
        regs_waddr_q <= pre_regs_waddr_i;
        regs_wdata_q <= pre_regs_wdata_i;
        pc_q         <= pre_pc_i;
      end
    end
  end

  // Capture the response when it arrives while writeback is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else if ((state_q == ST_WAIT) && data_ok_i && !next_allowin_i && !excep_flush_i)
      hold_q <= rdata_i;
  end

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .data     (load_src),
    .ld_type  (ld_type_q),
    .addr_low (addr_low_q),
    .result   (load_data)
  );

`ifdef MEM_RESP_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  // Saturating count of cycles spent waiting on the dcache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else if (need_data && !ready_go && (perf_q != {PERF_W{1'b1}}))
      perf_q <= perf_q + 1'b1;
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// Self-checking bench for mem_resp_stage. Writeback transfers are checked
// against a scoreboard of expected results pushed when each instruction
// is accepted; per-scenario tasks check handshake and hazard outputs.
module tb_mem_resp_stage;

`ifdef MEM_RESP_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        pre_valid_i;
  logic        now_allowin_o;
  logic        pre_mem_req_i;
  logic        pre_mem_we_i;
  logic [2:0]  pre_ld_type_i;
  logic [1:0]  pre_addr_low_i;
  logic        pre_excep_en_i;
  logic        pre_regs_we_i;
  logic [4:0]  pre_regs_waddr_i;
  logic [31:0] pre_regs_wdata_i;
  logic [31:0] pre_pc_i;
  logic        excep_flush_i;
  logic        data_ok_i;
  logic [31:0] rdata_i;
  logic        next_allowin_i;
  logic        now_to_next_valid_o;
  logic        regs_we_o;
  logic [4:0]  regs_waddr_o;
  logic [31:0] regs_wdata_o;
  logic [31:0] pc_o;
  logic        excep_en_o;
  logic        fwd_we_o;
  logic        fwd_stall_o;
  logic [31:0] perf_stall_cnt_o;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] perf_base;

  mem_resp_stage #(.DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pre_valid_i         (pre_valid_i),
    .now_allowin_o       (now_allowin_o),
    .pre_mem_req_i       (pre_mem_req_i),
    .pre_mem_we_i        (pre_mem_we_i),
    .pre_ld_type_i       (pre_ld_type_i),
    .pre_addr_low_i      (pre_addr_low_i),
    .pre_excep_en_i      (pre_excep_en_i),
    .pre_regs_we_i       (pre_regs_we_i),
    .pre_regs_waddr_i    (pre_regs_waddr_i),
    .pre_regs_wdata_i    (pre_regs_wdata_i),
    .pre_pc_i            (pre_pc_i),
    .excep_flush_i       (excep_flush_i),
    .data_ok_i           (data_ok_i),
    .rdata_i             (rdata_i),
    .next_allowin_i      (next_allowin_i),
    .now_to_next_valid_o (now_to_next_valid_o),
    .regs_we_o           (regs_we_o),
    .regs_waddr_o        (regs_waddr_o),
    .regs_wdata_o        (regs_wdata_o),
    .pc_o                (pc_o),
    .excep_en_o          (excep_en_o),
    .fwd_we_o            (fwd_we_o),
    .fwd_stall_o         (fwd_stall_o),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference load extraction using arithmetic shifts
  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [2:0] t,
                                           input logic [1:0] a);
    logic [31:0]        b;
    logic [31:0]        h;
    logic signed [31:0] s;
    b = d >> (8 * a);
    h = d >> (16 * a[1]);
    case (t)
      3'd0:    begin s = b << 24; return s >>> 24; end
      3'd1:    begin s = h << 16; return s >>> 16; end
      3'd4:    return b & 32'h0000_00FF;
      3'd5:    return h & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  // Present an instruction descriptor from the first memory stage
  task automatic drive_pre(input logic v, input logic req, input logic we,
                           input logic [2:0] t, input logic [1:0] a, input logic exc,
                           input logic rwe, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [31:0] pc);
    pre_valid_i      = v;
    pre_mem_req_i    = req;
    pre_mem_we_i     = we;
    pre_ld_type_i    = t;
    pre_addr_low_i   = a;
    pre_excep_en_i   = exc;
    pre_regs_we_i    = rwe;
    pre_regs_waddr_i = wa;
    pre_regs_wdata_i = wd;
    pre_pc_i         = pc;
  endtask

  // Called just after inputs settle; pops the scoreboard on a writeback
  // transfer, then moves to the next falling edge
  task automatic advance();
    exp_t e;
    if (now_to_next_valid_o && next_allowin_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got pc=%h expected no transfer", pc_o);
      end else begin
        e = sb.pop_front();
        if ({regs_waddr_o, regs_wdata_o, regs_we_o, pc_o, excep_en_o} !== e) begin
          bad++;
          $display("[TB] FAIL sb_wb: got waddr=%h wdata=%h we=%b pc=%h exc=%b expected waddr=%h wdata=%h we=%b pc=%h exc=%b",
                   regs_waddr_o, regs_wdata_o, regs_we_o, pc_o, excep_en_o,
                   e.waddr, e.wdata, e.we, e.pc, e.exc);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({now_allowin_o, now_to_next_valid_o, regs_we_o, fwd_we_o, fwd_stall_o, excep_en_o} !== 6'b100000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b expected 100000",
               {now_allowin_o, now_to_next_valid_o, regs_we_o, fwd_we_o, fwd_stall_o, excep_en_o});
    end
    total++;
    if ({regs_waddr_o, regs_wdata_o, pc_o, perf_stall_cnt_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: got waddr=%h wdata=%h pc=%h perf=%h expected all zero",
               regs_waddr_o, regs_wdata_o, pc_o, perf_stall_cnt_o);
    end
    advance();
    rst_n = 1'b1;
    #1;
    advance();
  endtask

  task automatic test_load_byte();
    perf_base = perf_stall_cnt_o;
    drive_pre(1, 1, 0, 3'd0, 2'd3, 0, 1, 5'd5, 32'h0, 32'h0000_0100);
    #1;
    sb.push_back('{5'd5, 32'hFFFF_FF80, 1'b1, 32'h0000_0100, 1'b0});
    advance();
    pre_valid_i = 0;
    data_ok_i   = 1;
    rdata_i     = 32'h80FF_0000;
    #1;
    total++;
    if ({now_to_next_valid_o, regs_wdata_o} !== {1'b1, 32'hFFFF_FF80}) begin
      bad++;
      $display("[TB] FAIL ldb_same_cycle: got valid=%b wdata=%h expected valid=1 wdata=ffffff80",
               now_to_next_valid_o, regs_wdata_o);
    end
    advance();
    data_ok_i = 0;
    #1;
    total++;
    if (now_to_next_valid_o !== 1'b0 || perf_stall_cnt_o !== perf_base) begin
      bad++;
      $display("[TB] FAIL ldb_after: got valid=%b perf=%0d expected valid=0 perf=%0d",
               now_to_next_valid_o, perf_stall_cnt_o, perf_base);
    end
    advance();
  endtask

  task automatic test_load_hold();
    perf_base = perf_stall_cnt_o;
    drive_pre(1, 1, 0, 3'd5, 2'd2, 0, 1, 5'd7, 32'h0, 32'h0000_0104);
    #1;
    sb.push_back('{5'd7, 32'h0000_BEEF, 1'b1, 32'h0000_0104, 1'b0});
    advance();
    pre_valid_i = 0;
    #1;
    total++;
    if ({fwd_stall_o, now_allowin_o, now_to_next_valid_o} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL hold_wait: got stall/allowin/valid=%b expected 100",
               {fwd_stall_o, now_allowin_o, now_to_next_valid_o});
    end
    advance();
    data_ok_i      = 1;
    rdata_i        = 32'hBEEF_1234;
    next_allowin_i = 0;
    #1;
    total++;
    if (now_allowin_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_capture_allowin: got %b expected 0", now_allowin_o);
    end
    advance();
    data_ok_i = 0;
    rdata_i   = 32'hDEAD_DEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({now_allowin_o, fwd_stall_o, regs_wdata_o} !== {2'b00, 32'h0000_BEEF}) begin
        bad++;
        $display("[TB] FAIL hold_cycle%0d: got allowin=%b stall=%b wdata=%h expected allowin=0 stall=0 wdata=0000beef",
                 i, now_allowin_o, fwd_stall_o, regs_wdata_o);
      end
      advance();
    end
    next_allowin_i = 1;
    #1;
    total++;
    if ({now_to_next_valid_o, now_allowin_o} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL hold_release: got valid/allowin=%b expected 11",
               {now_to_next_valid_o, now_allowin_o});
    end
    total++;
    if (perf_stall_cnt_o !== (PERF_EN ? perf_base + 32'd1 : 32'd0)) begin
      bad++;
      $display("[TB] FAIL hold_perf: got %0d expected %0d", perf_stall_cnt_o,
               PERF_EN ? perf_base + 32'd1 : 32'd0);
    end
    advance();
  endtask

  task automatic test_store();
    perf_base = perf_stall_cnt_o;
    drive_pre(1, 1, 1, 3'd2, 2'd0, 0, 0, 5'd0, 32'h0000_1234, 32'h0000_0108);
    #1;
    sb.push_back('{5'd0, 32'h0000_1234, 1'b0, 32'h0000_0108, 1'b0});
    advance();
    pre_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({fwd_stall_o, regs_we_o, now_to_next_valid_o} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL store_wait%0d: got stall/we/valid=%b expected 000",
                 i, {fwd_stall_o, regs_we_o, now_to_next_valid_o});
      end
      advance();
    end
    data_ok_i = 1;
    rdata_i   = 32'h7777_7777;
    #1;
    total++;
    if ({now_to_next_valid_o, regs_we_o} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL store_done: got valid/we=%b expected 10", {now_to_next_valid_o, regs_we_o});
    end
    total++;
    if (perf_stall_cnt_o !== (PERF_EN ? perf_base + 32'd3 : 32'd0)) begin
      bad++;
      $display("[TB] FAIL store_perf: got %0d expected %0d", perf_stall_cnt_o,
               PERF_EN ? perf_base + 32'd3 : 32'd0);
    end
    advance();
    data_ok_i = 0;
    #1;
    advance();
  endtask

  task automatic test_flush_drain();
    perf_base = perf_stall_cnt_o;
    drive_pre(1, 1, 0, 3'd2, 2'd0, 0, 1, 5'd9, 32'h0, 32'h0000_0200);
    #1;
    advance();
    pre_valid_i   = 0;
    excep_flush_i = 1;
    #1;
    total++;
    if ({now_to_next_valid_o, regs_we_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL flush_cycle: got valid/we=%b expected 00", {now_to_next_valid_o, regs_we_o});
    end
    advance();
    excep_flush_i = 0;
    drive_pre(1, 1, 0, 3'd2, 2'd0, 0, 1, 5'd10, 32'h0, 32'h0000_0204);
    #1;
    total++;
    if ({now_allowin_o, now_to_next_valid_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL drain_block: got allowin/valid=%b expected 00", {now_allowin_o, now_to_next_valid_o});
    end
    advance();
    data_ok_i = 1;
    rdata_i   = 32'h1111_1111;
    #1;
    total++;
    if ({now_allowin_o, now_to_next_valid_o, regs_we_o} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL drain_discard: got allowin/valid/we=%b expected 000",
               {now_allowin_o, now_to_next_valid_o, regs_we_o});
    end
    advance();
    data_ok_i = 0;
    #1;
    total++;
    if (now_allowin_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_exit: got allowin=%b expected 1", now_allowin_o);
    end
    sb.push_back('{5'd10, 32'hCAFE_F00D, 1'b1, 32'h0000_0204, 1'b0});
    advance();
    pre_valid_i = 0;
    data_ok_i   = 1;
    rdata_i     = 32'hCAFE_F00D;
    #1;
    total++;
    if (now_to_next_valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_next_load: got valid=%b expected 1", now_to_next_valid_o);
    end
    total++;
    if (perf_stall_cnt_o !== (PERF_EN ? perf_base + 32'd1 : 32'd0)) begin
      bad++;
      $display("[TB] FAIL drain_perf: got %0d expected %0d", perf_stall_cnt_o,
               PERF_EN ? perf_base + 32'd1 : 32'd0);
    end
    advance();
    data_ok_i = 0;
    #1;
    advance();
  endtask

  task automatic test_excep();
    perf_base = perf_stall_cnt_o;
    rdata_i   = 32'h55AA_55AA;
    drive_pre(1, 1, 0, 3'd2, 2'd0, 1, 1, 5'd3, 32'h0, 32'h0000_0300);
    #1;
    sb.push_back('{5'd3, 32'h55AA_55AA, 1'b0, 32'h0000_0300, 1'b1});
    advance();
    pre_valid_i = 0;
    #1;
    total++;
    if ({now_to_next_valid_o, excep_en_o, regs_we_o, fwd_stall_o} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL excep_pass: got valid/exc/we/stall=%b expected 1100",
               {now_to_next_valid_o, excep_en_o, regs_we_o, fwd_stall_o});
    end
    total++;
    if (perf_stall_cnt_o !== perf_base) begin
      bad++;
      $display("[TB] FAIL excep_perf: got %0d expected %0d", perf_stall_cnt_o, perf_base);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[6];
    logic [2:0]  t[6];
    logic [1:0]  a[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = $urandom;
      t[i] = 3'($urandom_range(0, 7));
      a[i] = 2'($urandom_range(0, 3));
    end
    drive_pre(1, 1, 0, t[0], a[0], 0, 1, 5'd16, 32'h0, 32'h0000_0400);
    #1;
    sb.push_back('{5'd16, ld_model(d[0], t[0], a[0]), 1'b1, 32'h0000_0400, 1'b0});
    advance();
    for (int k = 1; k <= 6; k++) begin
      data_ok_i = 1;
      rdata_i   = d[k-1];
      if (k < 6) begin
        drive_pre(1, 1, 0, t[k], a[k], 0, 1, 5'(16 + k), 32'h0, 32'h0000_0400 + 32'(4 * k));
        sb.push_back('{5'(16 + k), ld_model(d[k], t[k], a[k]), 1'b1,
                       32'h0000_0400 + 32'(4 * k), 1'b0});
      end else begin
        pre_valid_i = 0;
      end
      #1;
      total++;
      if ({now_to_next_valid_o, now_allowin_o} !== 2'b11) begin
        bad++;
        $display("[TB] FAIL b2b_%0d: got valid/allowin=%b expected 11", k,
                 {now_to_next_valid_o, now_allowin_o});
      end
      advance();
    end
    data_ok_i = 0;
    #1;
    total++;
    if (now_to_next_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_idle: got valid=%b expected 0", now_to_next_valid_o);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    drive_pre(1, 1, 0, 3'd2, 2'd0, 0, 1, 5'd1, 32'h0, 32'h0000_0500);
    #1;
    advance();
    pre_valid_i = 0;
    rst_n       = 0;
    #1;
    total++;
    if ({now_allowin_o, now_to_next_valid_o, fwd_stall_o, regs_we_o} !== 4'b1000 ||
        perf_stall_cnt_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got allowin/valid/stall/we=%b perf=%0d expected 1000 perf=0",
               {now_allowin_o, now_to_next_valid_o, fwd_stall_o, regs_we_o}, perf_stall_cnt_o);
    end
    advance();
    rst_n = 1;
    #1;
    advance();
  endtask

  // Scenario sequence
  initial begin
    rst_n          = 1'b1;
    excep_flush_i  = 0;
    data_ok_i      = 0;
    rdata_i        = '0;
    next_allowin_i = 1;
    drive_pre(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_byte();
    test_load_hold();
    test_store();
    test_flush_drain();
    test_excep();
    test_back_to_back();
    test_mid_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the width of data, address and PC.
REQ-002 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports pre_valid_i (in, 1) and now_allowin_o (out, 1), the upstream handshake from the first memory stage.
REQ-005 SHALL have pre_mem_req_i (in, 1), pre_mem_we_i (in, 1), pre_ld_type_i (in, 3), pre_addr_low_i (in, 2) and pre_excep_en_i (in, 1), the access descriptor.
REQ-006 SHALL have pre_regs_we_i (in, 1), pre_regs_waddr_i (in, 5), pre_regs_wdata_i (in, DATA_W) and pre_pc_i (in, DATA_W).
REQ-007 SHALL have excep_flush_i (in, 1), the pipeline exception flush.
REQ-008 SHALL have data_ok_i (in, 1) and rdata_i (in, DATA_W), the dcache response.
REQ-009 SHALL have next_allowin_i (in, 1) and now_to_next_valid_o (out, 1), the downstream handshake to writeback.
REQ-010 SHALL have regs_we_o (out, 1), regs_waddr_o (out, 5), regs_wdata_o (out, DATA_W), pc_o (out, DATA_W) and excep_en_o (out, 1).
REQ-011 SHALL have fwd_we_o (out, 1) and fwd_stall_o (out, 1), the forwarding/hazard outputs.
REQ-012 SHALL have perf_stall_cnt_o (out, 32), the stall counter (see Configuration).

Function
REQ-013 SHALL latch all pre_* fields on pre_valid_i & now_allowin_o; valid SHALL clear when now_allowin_o & ~pre_valid_i.
REQ-014 SHALL define need_data = valid & mem_req & ~excep_en; both loads and stores wait for data_ok_i.
REQ-015 SHALL implement FSM IDLE/WAIT/HOLD/DRAIN; accepting an instruction with req & ~excep_en SHALL enter WAIT, otherwise IDLE.
REQ-016 In WAIT with data_ok_i & ~next_allowin_i, the FSM SHALL capture rdata_i into a hold register and enter HOLD.
REQ-017 In WAIT with data_ok_i & next_allowin_i, the FSM SHALL pass rdata_i through in the same cycle (zero added latency).
REQ-018 HOLD SHALL use the hold register and leave on next_allowin_i.
REQ-019 excep_flush_i in WAIT without data_ok_i SHALL enter DRAIN; DRAIN SHALL discard exactly one data_ok_i, then go to IDLE.
REQ-020 excep_flush_i in IDLE or HOLD, or together with data_ok_i in WAIT, SHALL go to IDLE and clear valid.
REQ-021 SHALL compute ready_go = ~need_data | (WAIT & data_ok_i) | HOLD.
REQ-022 SHALL drive now_allowin_o = (~valid | ready_go & next_allowin_i) & (state != DRAIN).
REQ-023 SHALL drive now_to_next_valid_o = valid & ready_go & ~excep_flush_i.
REQ-024 Load extract: ld_type 0=ld.b, 1=ld.h, 2=ld.w, 4=ld.bu, 5=ld.hu.
REQ-025 SHALL select byte pre_addr_low_i, or half pre_addr_low_i[1], then sign- or zero-extend to DATA_W.
REQ-026 Other ld_type codes SHALL yield the full word.
REQ-027 regs_wdata_o SHALL equal the extracted data for loads (req & ~we) and latched regs_wdata otherwise.
REQ-028 SHALL drive regs_we_o = valid & regs_we & ~excep_en & ~excep_flush_i; excep_en_o = valid & excep_en.
REQ-029 SHALL drive fwd_we_o = regs_we_o and fwd_stall_o = valid & load & ~ready_go.

Reset
REQ-030 On rst_n low, asynchronously, state SHALL go to IDLE, valid and the hold register to 0, and all outputs to 0 except now_allowin_o = 1.
REQ-031 Reset mid-WAIT or mid-DRAIN SHALL drop the outstanding response tracking; the cache is reset together with this block.

Configuration
REQ-032 With macro MEM_RESP_PERF_CNT_EN defined, a 32-bit saturating counter SHALL increment each cycle need_data & ~ready_go, and SHALL hold at 0xFFFFFFFF.
REQ-033 Without MEM_RESP_PERF_CNT_EN, perf_stall_cnt_o SHALL be constant 0 and no counter SHALL be built.

Structure
REQ-034 ld_type codes, FSM encodings and the stage bus widths SHALL live in the shared define header.
REQ-035 Load extraction SHALL be one combinational sub-module, mem_load_align.

Verification
REQ-036 ld.b, addr_low=3, data_ok in the cycle after accept, rdata=0x80FF_0000 -> regs_wdata_o=0xFFFF_FF80, now_to_next_valid_o=1 in that cycle.
REQ-037 ld.hu, addr_low=2, next_allowin_i=0 for 3 cycles after data_ok, rdata=0xBEEF_1234 -> HOLD; output 0xBEEF on release; now_allowin_o=0 while held.
REQ-038 Store, data_ok after 4 cycles -> fwd_stall_o=0, regs_we_o=0, valid out only on data_ok; perf count +3 with macro.
REQ-039 Flush in WAIT, data_ok 2 cycles later -> DRAIN, now_allowin_o=0 until data_ok; no writeback; next load gets its own data.
REQ-040 Load with pre_excep_en_i=1 -> no wait, excep_en_o=1, regs_we_o=0, counter unchanged.
